// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell walks a WIDTH-bit operand pair LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic c2
);
  assign s  = a ^ b ^ c;
  assign c2 = (a & b) | (a & c) | (b & c);
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | one bit pair processed per clock, LSB first
// DONE  | one-cycle done pulse, result already published
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             b_bit;
  logic             fa_s;
  logic             fa_c2;
  logic             sub_q;
  logic             init_carry;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so the incoming carry is forced high.
  assign init_carry = sub ? 1'b1 : cin;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (state == IDLE && start) begin
      sub_q <= sub;
    end
  end
`else
  assign init_carry = cin;
  assign sub_q      = 1'b0;
`endif

  assign b_bit = b_sh[0] ^ sub_q;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_bit),
    .c  (carry),
    .s  (fa_s),
    .c2 (fa_c2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= init_carry;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= {fa_s, res[WIDTH-1:1]};
          carry <= fa_c2;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          if (cnt == LAST) begin
            sum   <= {fa_s, res[WIDTH-1:1]};
            cout  <= fa_c2;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed, table-driven bench for serial_add_ctrl at WIDTH=8.
// Subtract vectors are included when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_total;
  int n_pass;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Accept at edge k, expect busy through k+7, done/result after k+8, idle after k+9.
  task automatic do_op(input vec_t v, input string name);
    int early;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    early = 0;
    for (int i = 1; i < WIDTH; i++) begin
      if (!(busy === 1'b1 && done === 1'b0)) early++;
      @(posedge clk); #1;
    end
    if (!(busy === 1'b1 && done === 1'b0)) early++;
    chk({name, " busy_window"}, early, 0);
    @(posedge clk); #1;
    chk({name, " done"}, {busy, done}, 2'b01);
    chk({name, " sum"}, sum, v.exp_sum);
    chk({name, " cout"}, cout, v.exp_cout);
    @(posedge clk); #1;
    chk({name, " after"}, {busy, done}, 2'b00);
  endtask

  vec_t vecs[$];

  initial begin
    int dones, busy_low, bad_sum, first_done;
    n_total = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0});
    vecs.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
    vecs.push_back('{8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1});
`endif

    repeat (2) @(posedge clk);
    #1 chk("reset_in", {busy, done, cout, sum}, 11'h0);
    @(negedge clk); rst = 1'b0;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        if ({busy, done, cout, sum} !== 11'h0) bad++;
      end
      chk("reset_idle", bad, 0);
    end

    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // start re-pulsed mid-RUN must be ignored
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dones = 0; first_done = -1;
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) begin @(negedge clk); start = 1'b1; a = 8'h01; b = 8'h01; end
      @(posedge clk); #1;
      if (i == 3) start = 1'b0;
      if (done) begin dones++; if (first_done < 0) first_done = i; end
    end
    chk("ignore_start dones", dones, 1);
    chk("ignore_start when", first_done, WIDTH);
    chk("ignore_start sum", sum, 8'h97);
    chk("ignore_start cout", cout, 1'b0);

    // start held high: one op every WIDTH+2 cycles
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    dones = 0; busy_low = 0; bad_sum = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!busy) busy_low++;
      if (done) begin
        dones++;
        if (sum !== 8'h02 || i % 10 != 8) bad_sum++;
      end
      if (busy && done) bad_sum++;
    end
    start = 1'b0;
    chk("held dones", dones, 3);
    chk("held busy_low", busy_low, 6);
    chk("held pulses", bad_sum, 0);
    repeat (12) @(posedge clk);

    // reset mid-RUN aborts silently
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("abort outputs", {busy, done, cout, sum}, 11'h0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort no_done", dones, 0);
    do_op('{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0}, "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
